vip_matrix_3x3_gen: RTL and testbench
=====================================

Name: vip_matrix_3x3_gen

Overview:
- Builds a 3x3 grey-pixel window around the streaming image inside the vip chain.
- Sits directly downstream of the grey-conversion stage and directly upstream of the Sobel/Canny gradient stage.
- Consumes the pre_frame_* video timing plus 8-bit grey, in the cam_pclk domain.
- Emits nine window taps with timing delayed to match, and a flag marking windows built only from real image pixels.

Parameters:
H_DISP, 1280, active pixels per line; line-buffer depth.
V_DISP, 800, active lines per frame; row counter saturates at V_DISP-1.

Ports:
clk  input  1  pixel clock (cam_pclk)
rst  input  1  synchronous reset, active-high
pre_frame_vsync  input  1  frame sync; rising edge marks frame start
pre_frame_hsync  input  1  line valid (href)
pre_frame_de  input  1  pixel valid
pre_gray  input  8  grey pixel, qualified by pre_frame_de
post_frame_vsync  output  1  pre_frame_vsync delayed 2 clk
post_frame_hsync  output  1  pre_frame_hsync delayed 2 clk
post_frame_de  output  1  pre_frame_de delayed 2 clk, gated by armed
post_win_valid  output  1  window fully inside the image
matrix_p11..p13  output  8 each  top row (line n-2), oldest column first
matrix_p21..p23  output  8 each  middle row (line n-1)
matrix_p31..p33  output  8 each  bottom row (current line n); p33 = newest pixel

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on rising clk.
- Reset values:
  - All outputs are 0.
  - Counters col and row are 0.
  - Column shift registers are 0.
  - The armed flag is 0.
  - Line-buffer RAM contents are not reset.
- Armed flag:
  - Set on the first pre_frame_vsync rising edge after reset.
  - While unarmed, post_frame_de and post_win_valid are forced to 0, and no RAM writes occur.
  - Reset mid-frame therefore discards the rest of that frame.
- col counter:
  - Increments on each pre_frame_de.
  - Saturates at H_DISP.
  - Cleared when pre_frame_hsync is low.
- row counter:
  - Increments on the hsync falling edge only if the line had at least one de.
  - Saturates at V_DISP-1.
  - Cleared on vsync rising edge.
  - Vsync rising edge and hsync falling edge in the same cycle: clear wins.
- Line buffers: two single-port-read/single-port-write RAMs, lb1 and lb2, depth H_DISP, 8 bits, synchronous read (1 clk).
  - On de with col<H_DISP: read lb1[col] and lb2[col].
  - Same cycle, write lb1[col]=pre_gray and lb2[col]=lb1 read data (read-before-write).
  - col>=H_DISP (overlong line): writes suppressed, read data treated as 0, post_win_valid=0.
- Pipeline:
  - Stage 1: RAM read, plus pre_gray, de, hsync and vsync registered.
  - Stage 2: column shift. On stage-1 de, each row shifts p_x1<=p_x2 and p_x2<=p_x3, then loads the new p_x3:
    - row 1 from the lb2 output;
    - row 2 from the lb1 output;
    - row 3 from the delayed pre_gray.
  - Latency: pre → post is exactly 2 clk for de, hsync, vsync and taps.
  - Taps hold their value when de is low.
- Zero-fill at frame edges:
  - Row 0: top and middle row inputs forced to 0.
  - Row 1: top row input forced to 0.
  - Shift registers cleared on hsync rising edge, so the first two windows of each line carry zeros in the left columns.
- post_win_valid = post_frame_de AND the window's row>=2 AND col>=2 AND col<H_DISP, evaluated in the same 2-clk-aligned cycle as the taps.
- No backpressure: one pixel accepted per clk when de=1; consecutive de with no gaps is supported.

Test Plan:
- Reset mid-frame, H_DISP=8, V_DISP=6:
  - Stimulus: rst high for 1 clk during line 3.
  - Required: all outputs 0 the next cycle; post_frame_de stays 0 until the next vsync rising edge, then tracks pre_frame_de with 2-clk delay.
- Ramp frame, H_DISP=8, V_DISP=6, pixel value = row*16+col:
  - At row 3, col 4: p11..p13=0x12,0x13,0x14; p21..p23=0x22,0x23,0x24; p31..p33=0x32,0x33,0x34; post_win_valid=1.
- Edge zero-fill on the same ramp frame:
  - Row 0, col 0: p33=0x00 and all other taps 0; post_win_valid=0.
  - Row 1, col 3: p11..p13=0; p21..p23=0x01,0x02,0x03; post_win_valid=0.
- Timing and gaps:
  - Stimulus: de toggling 1,0,1 within a line.
  - Required: post_frame_de shows 1,0,1 exactly 2 clk later; taps frozen during the gap cycle.
- Overlong line:
  - Stimulus: 10 de pulses in a line with H_DISP=8.
  - Required: post_win_valid=0 for pixels 8 and 9; the next line's middle row still equals the first 8 pixels.
- Back-to-back frames:
  - Stimulus: second vsync rising edge arrives coincident with the last line's hsync fall.
  - Required: row restarts at 0, and the new frame's rows 0-1 are zero-filled with no leakage from the old frame.

Source files
------------

// File: rtl/vip_matrix_3x3_gen.sv
// vip_matrix_3x3_gen: 3x3 grey window generator for the vip chain.
// Two line buffers plus column shift registers, 2-clk aligned timing.
module vip_matrix_3x3_gen #(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_hsync,
    input  logic       pre_frame_de,
    input  logic [7:0] pre_gray,
    output logic       post_frame_vsync,
    output logic       post_frame_hsync,
    output logic       post_frame_de,
    output logic       post_win_valid,
    output logic [7:0] matrix_p11,
    output logic [7:0] matrix_p12,
    output logic [7:0] matrix_p13,
    output logic [7:0] matrix_p21,
    output logic [7:0] matrix_p22,
    output logic [7:0] matrix_p23,
    output logic [7:0] matrix_p31,
    output logic [7:0] matrix_p32,
    output logic [7:0] matrix_p33
);

    localparam int CW = $clog2(H_DISP + 1);
    localparam int AW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int RW = (V_DISP > 1) ? $clog2(V_DISP) : 1;

    localparam logic [CW-1:0] C_HMAX = CW'(H_DISP);
    localparam logic [CW-1:0] C_COL2 = CW'(2);
    localparam logic [RW-1:0] C_VMAX = RW'(V_DISP - 1);
    localparam logic [RW-1:0] C_ROW1 = RW'(1);
    localparam logic [RW-1:0] C_ROW2 = RW'(2);

    // input-side control state
    logic          r_armed;
    logic          r_vs_d;
    logic          r_hs_d;
    logic          r_line_de;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // line buffers and their read registers
    logic [7:0]    r_lb1 [H_DISP];
    logic [7:0]    r_lb2 [H_DISP];
    logic [7:0]    r_lb1_q;
    logic [7:0]    r_lb2_q;

    // stage-1 registers
    logic          r_s1_de;
    logic          r_s1_hs;
    logic          r_s1_vs;
    logic          r_s1_inb;
    logic          r_s1_wr;
    logic [AW-1:0] r_s1_addr;
    logic [CW-1:0] r_s1_col;
    logic [RW-1:0] r_s1_row;
    logic [7:0]    r_s1_gray;

    // stage-2 registers (outputs)
    logic          r_post_vs;
    logic          r_post_hs;
    logic          r_post_de;
    logic          r_post_wv;
    logic [2:0][7:0] r_top;
    logic [2:0][7:0] r_mid;
    logic [2:0][7:0] r_bot;

    logic          w_vs_rise;
    logic          w_hs_fall;
    logic          w_de;
    logic          w_inb;
    logic          w_rd;
    logic [AW-1:0] w_addr;
    logic          w_s1_hs_rise;
    logic [7:0]    w_top_in;
    logic [7:0]    w_mid_in;
    logic          w_win;
    logic [2:0][7:0] w_top_base;
    logic [2:0][7:0] w_mid_base;
    logic [2:0][7:0] w_bot_base;

    assign w_vs_rise = pre_frame_vsync & ~r_vs_d;
    assign w_hs_fall = ~pre_frame_hsync & r_hs_d;
    // pixels arriving before the first frame start are ignored entirely
    assign w_de      = pre_frame_de & r_armed;
    assign w_inb     = (r_col < C_HMAX);
    assign w_rd      = w_de & w_inb;
    assign w_addr    = r_col[AW-1:0];

    // edge detect, arming, column and row counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed   <= 1'b0;
            r_vs_d    <= pre_frame_vsync;
            r_hs_d    <= 1'b0;
            r_line_de <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
        end else begin
            r_vs_d <= pre_frame_vsync;
            r_hs_d <= pre_frame_hsync;
            if (w_vs_rise) begin
                r_armed <= 1'b1;
            end
            if (!pre_frame_hsync) begin
                r_col     <= '0;
                r_line_de <= 1'b0;
            end else begin
                if (w_rd) begin
                    r_col <= r_col + 1'b1;
                end
                if (w_de) begin
                    r_line_de <= 1'b1;
                end
            end
            if (w_vs_rise) begin
                r_row <= '0;
            end else if (w_hs_fall && r_line_de && r_row != C_VMAX) begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    // line buffers: lb2 takes lb1's old word one cycle later, same address
    always_ff @(posedge clk) begin
        if (w_rd) begin
            r_lb1[w_addr] <= pre_gray;
            r_lb1_q       <= r_lb1[w_addr];
            r_lb2_q       <= r_lb2[w_addr];
        end
        if (r_s1_wr) begin
            r_lb2[r_s1_addr] <= r_lb1_q;
        end
    end

    // stage 1: align timing and pixel position with the RAM read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_de   <= 1'b0;
            r_s1_hs   <= 1'b0;
            r_s1_vs   <= 1'b0;
            r_s1_inb  <= 1'b0;
            r_s1_wr   <= 1'b0;
            r_s1_addr <= '0;
            r_s1_col  <= '0;
            r_s1_row  <= '0;
            r_s1_gray <= '0;
        end else begin
            r_s1_de   <= w_de;
            r_s1_hs   <= pre_frame_hsync;
            r_s1_vs   <= pre_frame_vsync;
            r_s1_inb  <= w_inb;
            r_s1_wr   <= w_rd;
            r_s1_addr <= w_addr;
            r_s1_col  <= r_col;
            r_s1_row  <= r_row;
            r_s1_gray <= pre_gray;
        end
    end

    assign w_s1_hs_rise = r_s1_hs & ~r_post_hs;
    assign w_top_in = (r_s1_inb && r_s1_row >= C_ROW2) ? r_lb2_q : 8'h00;
    assign w_mid_in = (r_s1_inb && r_s1_row >= C_ROW1) ? r_lb1_q : 8'h00;
    assign w_win = r_s1_de & r_s1_inb
                 & (r_s1_row >= C_ROW2) & (r_s1_col >= C_COL2);
    assign w_top_base = w_s1_hs_rise ? '0 : r_top;
    assign w_mid_base = w_s1_hs_rise ? '0 : r_mid;
    assign w_bot_base = w_s1_hs_rise ? '0 : r_bot;

    // stage 2: column shift with line-start clear, delayed timing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_post_vs <= 1'b0;
            r_post_hs <= 1'b0;
            r_post_de <= 1'b0;
            r_post_wv <= 1'b0;
            r_top     <= '0;
            r_mid     <= '0;
            r_bot     <= '0;
        end else begin
            r_post_vs <= r_s1_vs;
            r_post_hs <= r_s1_hs;
            r_post_de <= r_s1_de;
            r_post_wv <= w_win;
            if (r_s1_de) begin
                r_top <= {w_top_in, w_top_base[2:1]};
                r_mid <= {w_mid_in, w_mid_base[2:1]};
                r_bot <= {r_s1_gray, w_bot_base[2:1]};
            end else if (w_s1_hs_rise) begin
                r_top <= '0;
                r_mid <= '0;
                r_bot <= '0;
            end
        end
    end

    assign post_frame_vsync = r_post_vs;
    assign post_frame_hsync = r_post_hs;
    assign post_frame_de    = r_post_de;
    assign post_win_valid   = r_post_wv;
    assign matrix_p11 = r_top[0];
    assign matrix_p12 = r_top[1];
    assign matrix_p13 = r_top[2];
    assign matrix_p21 = r_mid[0];
    assign matrix_p22 = r_mid[1];
    assign matrix_p23 = r_mid[2];
    assign matrix_p31 = r_bot[0];
    assign matrix_p32 = r_bot[1];
    assign matrix_p33 = r_bot[2];

endmodule

// File: tb/tb_vip_matrix_3x3_gen.sv
// tb_vip_matrix_3x3_gen: directed bench, H_DISP=8, V_DISP=6.
// Ramp frames, reset mid-frame, de gap, overlong line, back-to-back frames.
module tb_vip_matrix_3x3_gen;

    logic       clk;
    logic       rst;
    logic       pre_frame_vsync;
    logic       pre_frame_hsync;
    logic       pre_frame_de;
    logic [7:0] pre_gray;
    logic       post_frame_vsync;
    logic       post_frame_hsync;
    logic       post_frame_de;
    logic       post_win_valid;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;

    vip_matrix_3x3_gen #(.H_DISP(8), .V_DISP(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_hsync  (pre_frame_hsync),
        .pre_frame_de     (pre_frame_de),
        .pre_gray         (pre_gray),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_hsync (post_frame_hsync),
        .post_frame_de    (post_frame_de),
        .post_win_valid   (post_win_valid),
        .matrix_p11       (matrix_p11),
        .matrix_p12       (matrix_p12),
        .matrix_p13       (matrix_p13),
        .matrix_p21       (matrix_p21),
        .matrix_p22       (matrix_p22),
        .matrix_p23       (matrix_p23),
        .matrix_p31       (matrix_p31),
        .matrix_p32       (matrix_p32),
        .matrix_p33       (matrix_p33)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gapc = 0;
    int vsc = 0;
    int s = 0;
    int pc [8][10];

    logic [71:0] h_tap [1024];
    logic        h_de  [1024];
    logic        h_wv  [1024];
    logic        h_hs  [1024];
    logic        h_vs  [1024];
    logic        any;

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // apply inputs, step one clock, snapshot outputs 1 time unit later
    task automatic drive(input logic vs, input logic hs, input logic de,
                         input logic [7:0] g);
        pre_frame_vsync = vs;
        pre_frame_hsync = hs;
        pre_frame_de    = de;
        pre_gray        = g;
        @(posedge clk);
        #1;
        cyc++;
        h_tap[cyc] = {matrix_p11, matrix_p12, matrix_p13,
                      matrix_p21, matrix_p22, matrix_p23,
                      matrix_p31, matrix_p32, matrix_p33};
        h_de[cyc] = post_frame_de;
        h_wv[cyc] = post_win_valid;
        h_hs[cyc] = post_frame_hsync;
        h_vs[cyc] = post_frame_vsync;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic vs_pulse();
        vsc = cyc + 1;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        idle(2);
    endtask

    // one line: hsync lead cycle, npix pixels, optional de gap after col gap
    task automatic line(input int r, input int npix, input int gap,
                        input logic [7:0] base);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < npix; c++) begin
            pc[r][c] = cyc + 1;
            drive(1'b0, 1'b1, 1'b1, base + 8'(r * 16 + c));
            if (c == gap) begin
                gapc = cyc + 1;
                drive(1'b0, 1'b1, 1'b0, 8'hEE);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'hAB);
        drive(1'b1, 1'b1, 1'b1, 8'hAB);
        chk("rst_taps", h_tap[cyc], 72'h0);
        chk("rst_ctl", 72'({h_de[cyc], h_wv[cyc], h_hs[cyc], h_vs[cyc]}), 72'h0);
        rst = 1'b0;
        idle(2);

        // frame 1: reset during line 3
        vs_pulse();
        for (int r = 0; r < 3; r++) begin
            line(r, 8, -1, 8'h00);
            idle(3);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 3; c++) drive(1'b0, 1'b1, 1'b1, 8'(8'h30 + c));
        chk("pre_rst_de", 72'(h_de[cyc]), 72'd1);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'h33);
        rst = 1'b0;
        chk("midrst_taps", h_tap[cyc], 72'h0);
        chk("midrst_ctl", 72'({h_de[cyc], h_wv[cyc], h_hs[cyc], h_vs[cyc]}), 72'h0);
        s = cyc;
        for (int c = 4; c < 8; c++) drive(1'b0, 1'b1, 1'b1, 8'(8'h30 + c));
        idle(3);
        line(4, 8, -1, 8'h00);
        idle(3);
        line(5, 8, -1, 8'h00);
        idle(3);
        any = 1'b0;
        for (int i = s + 1; i <= cyc; i++) any = any | h_de[i] | h_wv[i];
        chk("unarmed_de", 72'(any), 72'd0);

        // frame 2: ramp, gap on row 4, overlong row 5, extra line
        vs_pulse();
        chk("vs_early", 72'(h_vs[vsc]), 72'd0);
        chk("vs_delay", 72'(h_vs[vsc + 1]), 72'd1);
        for (int r = 0; r < 4; r++) begin
            line(r, 8, -1, 8'h00);
            idle(3);
        end
        line(4, 8, 1, 8'h00);
        idle(3);
        line(5, 10, -1, 8'h00);
        idle(3);
        line(6, 8, -1, 8'h00);
        // next frame start coincides with the hsync fall
        vs_pulse();

        chk("r0c0_de_early", 72'(h_de[pc[0][0]]), 72'd0);
        chk("r0c0_de", 72'(h_de[pc[0][0] + 1]), 72'd1);
        chk("r0c0_taps", h_tap[pc[0][0] + 1], 72'h0);
        chk("r0c0_wv", 72'(h_wv[pc[0][0] + 1]), 72'd0);
        chk("hs_early", 72'(h_hs[pc[2][0] - 1]), 72'd0);
        chk("hs_delay", 72'(h_hs[pc[2][0]]), 72'd1);
        chk("r1c3_taps", h_tap[pc[1][3] + 1], 72'h000000_010203_111213);
        chk("r1c3_wv", 72'(h_wv[pc[1][3] + 1]), 72'd0);
        chk("r3c4_taps", h_tap[pc[3][4] + 1], 72'h121314_222324_323334);
        chk("r3c4_wv", 72'(h_wv[pc[3][4] + 1]), 72'd1);
        chk("gap_de_a", 72'(h_de[pc[4][1] + 1]), 72'd1);
        chk("gap_de_b", 72'(h_de[gapc + 1]), 72'd0);
        chk("gap_de_c", 72'(h_de[pc[4][2] + 1]), 72'd1);
        chk("gap_before", h_tap[pc[4][1] + 1], 72'h002021_003031_004041);
        chk("gap_frozen", h_tap[gapc + 1], 72'h002021_003031_004041);
        chk("gap_after", h_tap[pc[4][2] + 1], 72'h202122_303132_404142);
        chk("gap_after_wv", 72'(h_wv[pc[4][2] + 1]), 72'd1);
        chk("long_c7_wv", 72'(h_wv[pc[5][7] + 1]), 72'd1);
        chk("long_c8_wv", 72'(h_wv[pc[5][8] + 1]), 72'd0);
        chk("long_c9_wv", 72'(h_wv[pc[5][9] + 1]), 72'd0);
        chk("long_c9_de", 72'(h_de[pc[5][9] + 1]), 72'd1);
        chk("after_long_c2", h_tap[pc[6][2] + 1], 72'h404142_505152_606162);
        chk("after_long_c7", h_tap[pc[6][7] + 1], 72'h454647_555657_656667);

        // frame 3: new data, rows 0-1 must not leak frame 2 contents
        for (int r = 0; r < 3; r++) begin
            line(r, 8, -1, 8'h80);
            idle(3);
        end
        chk("f3r0c3_taps", h_tap[pc[0][3] + 1], 72'h000000_000000_818283);
        chk("f3r0c3_wv", 72'(h_wv[pc[0][3] + 1]), 72'd0);
        chk("f3r1c3_taps", h_tap[pc[1][3] + 1], 72'h000000_818283_919293);
        chk("f3r1c3_wv", 72'(h_wv[pc[1][3] + 1]), 72'd0);
        chk("f3r2c3_taps", h_tap[pc[2][3] + 1], 72'h818283_919293_A1A2A3);
        chk("f3r2c3_wv", 72'(h_wv[pc[2][3] + 1]), 72'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
